pll_clk_supervisor: RTL

PLL_CLK_SUPERVISOR -- requirements
Module: pll_clk_supervisor

---
 rtl/pll_clk_supervisor.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pll_clk_supervisor.sv
// ---------------------------------------------------------------------------
// pll_clk_supervisor
//
// Watches the PLL lock indication and sequences the per-domain resets and
// clock-enable strobes. Lock must be continuously present for LOCK_STABLE
// cycles before any domain leaves reset. Domains are then released one at a
// time, RST_STAGGER cycles apart. Once every domain is out of reset the
// per-channel tick dividers start running. Any loss of lock after
// stabilisation drops everything back into reset and is counted.
//
// Ports:
//   clk           system clock (PLL primary output)
//   nrst          asynchronous active-low reset
//   pll_locked    raw PLL lock, asynchronous to clk
//   ch_en         per-channel tick enable
//   ch_div        per-channel divisor, channel i at [i*CNT_W +: CNT_W]
//   rst_out_n     per-domain active-low reset
//   tick          one-cycle clock-enable strobes
//   ready         all domains released and PLL stable
//   state         00 WAIT_LOCK, 01 STABILISE, 10 RELEASE, 11 RUN
//   lock_loss_cnt saturating count of lock losses after stabilisation
// ---------------------------------------------------------------------------
module pll_clk_supervisor #(
  parameter int NUM_CH      = 3,
  parameter int CNT_W       = 24,
  parameter int LOCK_STABLE = 1024,
  parameter int RST_STAGGER = 16
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    pll_locked,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*CNT_W-1:0] ch_div,
  output logic [NUM_CH-1:0]       rst_out_n,
  output logic [NUM_CH-1:0]       tick,
  output logic                    ready,
  output logic [1:0]              state,
  output logic [7:0]              lock_loss_cnt
);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'b00,
    S_STABILISE = 2'b01,
    S_RELEASE   = 2'b10,
    S_RUN       = 2'b11
  } state_t;

  localparam int STAB_W  = (LOCK_STABLE > 2) ? $clog2(LOCK_STABLE) : 1;
  localparam int REL_MAX = NUM_CH * RST_STAGGER;
  localparam int REL_W   = $clog2(REL_MAX + 1);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
  localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(REL_MAX);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_sync1;
  logic                r_lock_s;
  logic [STAB_W-1:0]   r_stab_cnt;
  logic [REL_W-1:0]    r_rel_cnt;
  logic [REL_W-1:0]    w_rel_next;
  logic [NUM_CH-1:0]   r_rst_n;
  logic [NUM_CH-1:0]   r_tick;
  logic                r_ready;
  logic [7:0]          r_loss_cnt;
  logic [CNT_W-1:0]    r_cnt [NUM_CH];
  logic [CNT_W-1:0]    w_div [NUM_CH];
  logic                w_run;

  assign w_rel_next = r_rel_cnt + REL_W'(1);

  // Dividers only advance while staying in RUN, so the cycle that leaves RUN
  // already shows tick=0 together with the reset assertion.
  assign w_run = (r_state == S_RUN) && (w_next_state == S_RUN);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_div
    assign w_div[g] = ch_div[g*CNT_W +: CNT_W];
  end

  // Two-flop synchroniser; nothing else looks at pll_locked.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_locked;
      r_lock_s <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_WAIT_LOCK;
    else       r_state <= w_next_state;
  end

  // Losing synchronised lock always wins over any progress in the sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_WAIT_LOCK: if (r_lock_s) w_next_state = S_STABILISE;
      S_STABILISE: begin
        if (!r_lock_s)                    w_next_state = S_WAIT_LOCK;
        else if (r_stab_cnt == STAB_LAST) w_next_state = S_RELEASE;
      end
      S_RELEASE: begin
        if (!r_lock_s)                 w_next_state = S_WAIT_LOCK;
        else if (w_rel_next == REL_LAST) w_next_state = S_RUN;
      end
      S_RUN:   if (!r_lock_s) w_next_state = S_WAIT_LOCK;
      default: w_next_state = S_WAIT_LOCK;
    endcase
  end

  // Stability and release timers restart on every state entry. Resets are
  // released as the release timer passes each channel's threshold and held
  // high until the sequence falls back to WAIT_LOCK.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_stab_cnt <= '0;
      r_rel_cnt  <= '0;
      r_rst_n    <= '0;
      r_ready    <= 1'b0;
      r_loss_cnt <= '0;
    end else begin
      r_stab_cnt <= ((r_state == S_STABILISE) && (w_next_state == S_STABILISE))
                    ? r_stab_cnt + STAB_W'(1) : '0;
      r_rel_cnt  <= ((r_state == S_RELEASE) && (w_next_state == S_RELEASE))
                    ? w_rel_next : '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_rst_n[k] <= ((w_next_state == S_RELEASE) || (w_next_state == S_RUN)) &&
                      (r_rst_n[k] ||
                       ((r_state == S_RELEASE) &&
                        (w_rel_next >= REL_W'((k + 1) * RST_STAGGER))));
      end
      r_ready <= (w_next_state == S_RUN);
      if (((r_state == S_RELEASE) || (r_state == S_RUN)) && !r_lock_s &&
          (r_loss_cnt != 8'hFF)) begin
        r_loss_cnt <= r_loss_cnt + 8'd1;
      end
    end
  end

  // Per-channel dividers. Comparing with >= rather than == lets a lowered
  // divisor tick and wrap on the next cycle instead of counting to overflow.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
      r_tick <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_run && ch_en[i] && (w_div[i] != '0)) begin
          if (r_cnt[i] >= (w_div[i] - CNT_W'(1))) begin
            r_cnt[i]  <= '0;
            r_tick[i] <= 1'b1;
          end else begin
            r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
            r_tick[i] <= 1'b0;
          end
        end else begin
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b0;
        end
      end
    end
  end

  assign rst_out_n     = r_rst_n;
  assign tick          = r_tick;
  assign ready         = r_ready;
  assign state         = r_state;
  assign lock_loss_cnt = r_loss_cnt;

endmodule
